// File: rtl/meas_fifo.sv
// meas_fifo: ordered measurement queue between the TDC core and the UART
// transmitter. A drain FSM launches one UART frame per stored word using the
// transmitter's start-pulse / busy handshake. Overflow drops are counted
// (saturating) and flagged (sticky until cleared).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | wait for a stored word and an idle UART; pop on exit
// LAUNCH    | popped word sits in out_data; raise out_start, arm timer
// WAIT_BUSY | wait for UART busy; give up (word counts as sent) on timeout
// WAIT_DONE | UART transmitting; return to IDLE when busy drops

module meas_fifo #(
   parameter int WIDTH        = 40,
   parameter int DEPTH        = 16,
   parameter int BUSY_TIMEOUT = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WIDTH-1:0]         in_data,
   input  logic                     in_valid,
   output logic [WIDTH-1:0]         out_data,
   output logic                     out_start,
   input  logic                     out_busy,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty,
   output logic [15:0]              drop_count,
   output logic                     overflow,
   input  logic                     clr_overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int TW = $clog2(BUSY_TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]    level_q, level_d;
   logic             full_q, empty_q;
   logic [15:0]      drop_count_q;
   logic             overflow_q;
   state_t           state_q;
   logic [WIDTH-1:0] out_data_q;
   logic             out_start_q;
   logic [TW-1:0]    tmr_q;
   logic             pop, push_ok, drop;

   // Handshake decode: pop only on IDLE->LAUNCH; a pop frees a slot for a same-cycle push.
   always_comb begin
      pop     = (state_q == IDLE) && (level_q != '0) && !out_busy;
      push_ok = in_valid && ((level_q != LW'(DEPTH)) || pop);
      drop    = in_valid && !push_ok;
      level_d = level_q;
      if (push_ok && !pop)
         level_d = level_q + LW'(1);
      else if (!push_ok && pop)
         level_d = level_q - LW'(1);
   end

   // Storage array; contents need no reset since level gates every read.
   always_ff @(posedge clk) begin
      if (push_ok)
         mem_q[wr_ptr_q] <= in_data;
   end

   // Pointers, occupancy and flags registered from the next level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         if (push_ok)
            wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)
            rd_ptr_q <= rd_ptr_q + AW'(1);
         level_q <= level_d;
         full_q  <= (level_d == LW'(DEPTH));
         empty_q <= (level_d == '0);
      end
   end

   // Drop accounting; a drop in the same cycle as a clear wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_count_q <= '0;
         overflow_q   <= 1'b0;
      end else if (drop) begin
         overflow_q <= 1'b1;
         if (clr_overflow)
            drop_count_q <= 16'd1;
         else if (drop_count_q != 16'hFFFF)
            drop_count_q <= drop_count_q + 16'd1;
      end else if (clr_overflow) begin
         drop_count_q <= '0;
         overflow_q   <= 1'b0;
      end
   end

   // Drain FSM with registered out_data/out_start and a down-counting busy timeout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         out_data_q  <= '0;
         out_start_q <= 1'b0;
         tmr_q       <= '0;
      end else begin
         out_start_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (pop) begin
                  out_data_q <= mem_q[rd_ptr_q];
                  state_q    <= LAUNCH;
               end
            end
            LAUNCH: begin
               out_start_q <= 1'b1;
               tmr_q       <= TW'(BUSY_TIMEOUT - 1);
               state_q     <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               if (out_busy)
                  state_q <= WAIT_DONE;
               else if (tmr_q == '0)
                  state_q <= IDLE;
               else
                  tmr_q <= tmr_q - TW'(1);
            end
            WAIT_DONE: begin
               if (!out_busy)
                  state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign out_data   = out_data_q;
   assign out_start  = out_start_q;
   assign level      = level_q;
   assign full       = full_q;
   assign empty      = empty_q;
   assign drop_count = drop_count_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_meas_fifo.sv
// Scoreboard bench for meas_fifo: stimulus pushes expected words into a queue,
// a negedge monitor pops and compares on every out_start.
module tb_meas_fifo;

   localparam int W = 40;
   localparam int D = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [W-1:0]  in_data = '0;
   logic          in_valid = 1'b0;
   logic [W-1:0]  out_data;
   logic          out_start;
   logic          out_busy;
   logic [4:0]    level;
   logic          full, empty;
   logic [15:0]   drop_count;
   logic          overflow;
   logic          clr_overflow = 1'b0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int launches = 0;
   logic [W-1:0] exp_q[$];
   int launch_cyc_q[$];

   logic hold_busy = 1'b0;
   int   busy_len = 0;
   int   busy_cnt = 0;

   meas_fifo #(.WIDTH(W), .DEPTH(D), .BUSY_TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .out_data(out_data), .out_start(out_start), .out_busy(out_busy),
      .level(level), .full(full), .empty(empty), .drop_count(drop_count),
      .overflow(overflow), .clr_overflow(clr_overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // UART model: busy rises the cycle after out_start for busy_len cycles.
   always @(posedge clk or posedge rst) begin
      if (rst) busy_cnt <= 0;
      else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
      else if (out_start && busy_len > 0) busy_cnt <= busy_len;
   end
   assign out_busy = hold_busy || (busy_cnt > 0);

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every launch must match the head of the expected queue.
   always @(negedge clk) begin
      if (!rst && out_start) begin
         launches++;
         launch_cyc_q.push_back(cyc);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_launch: got data %0h expected no launch", out_data);
         end else begin
            check("launch_data", out_data, exp_q.pop_front());
         end
         check("launch_busy_low", out_busy, 0);
      end
   end

   task automatic push(input logic [W-1:0] d, input bit acc, output int c);
      @(negedge clk);
      in_data  = d;
      in_valid = 1'b1;
      if (acc) exp_q.push_back(d);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      c = cyc;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (n < 6000 && !(exp_q.size() == 0 && empty && !out_busy)) begin
         @(posedge clk);
         n++;
      end
      repeat (8) @(posedge clk);
      #1;
      check(name, (n < 6000), 1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int pc, l0, g;
      // Reset applied between clock edges: outputs must clear without a clock.
      #1 rst = 1'b1;
      #1;
      check("rst_level", level, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_out_start", out_start, 0);
      check("rst_out_data", out_data, 0);
      check("rst_drop_count", drop_count, 0);
      check("rst_overflow", overflow, 0);
      @(negedge clk) rst = 1'b0;
      repeat (2) @(posedge clk);

      // 1: single word, latency and single launch
      busy_len = 100;
      launch_cyc_q.delete();
      l0 = launches;
      push(40'h00_0000_0123, 1, pc);
      drain("t1_drain");
      check("t1_launch_count", launches - l0, 1);
      check("t1_latency", (launch_cyc_q.size() > 0) ? launch_cyc_q[0] - pc : -1, 2);
      check("t1_level", level, 0);
      check("t1_empty", empty, 1);

      // 2: burst of 5 while UART busy, in-order drain, gap = busy + 4 edges
      busy_len = 1000;
      hold_busy = 1'b1;
      for (int i = 1; i <= 5; i++) push(W'(i), 1, pc);
      check("t2_peak_level", level, 5);
      @(negedge clk) hold_busy = 1'b0;
      launch_cyc_q.delete();
      l0 = launches;
      drain("t2_drain");
      check("t2_launch_count", launches - l0, 5);
      for (int i = 1; i < 5; i++) begin
         g = (launch_cyc_q.size() == 5) ? launch_cyc_q[i] - launch_cyc_q[i-1] : -1;
         check("t2_gap", g, 1004);
      end

      // 3: overflow, drop counting, clear, clear-vs-drop priority
      busy_len = 3;
      hold_busy = 1'b1;
      for (int i = 0; i < D + 3; i++) push(W'(32'h100 + i), (i < D), pc);
      check("t3_full", full, 1);
      check("t3_level", level, 16);
      check("t3_drop_count", drop_count, 3);
      check("t3_overflow", overflow, 1);
      @(negedge clk) clr_overflow = 1'b1;
      @(posedge clk) #1 clr_overflow = 1'b0;
      check("t3_clr_drop_count", drop_count, 0);
      check("t3_clr_overflow", overflow, 0);
      @(negedge clk);
      in_data = 40'hDEAD; in_valid = 1'b1; clr_overflow = 1'b1;
      @(posedge clk) #1;
      in_valid = 1'b0; clr_overflow = 1'b0;
      check("t3_clrdrop_count", drop_count, 1);
      check("t3_clrdrop_overflow", overflow, 1);
      check("t3_clrdrop_level", level, 16);
      @(negedge clk) clr_overflow = 1'b1;
      @(posedge clk) #1 clr_overflow = 1'b0;
      check("t3_clr2_drop_count", drop_count, 0);
      @(negedge clk) hold_busy = 1'b0;
      drain("t3_drain");
      check("t3_level_after", level, 0);

      // 4: push into a full FIFO in the same cycle as a pop
      hold_busy = 1'b1;
      for (int i = 0; i < D; i++) push(W'(32'h200 + i), 1, pc);
      @(negedge clk);
      hold_busy = 1'b0;
      in_data = 40'hAB_CDEF_0123; in_valid = 1'b1;
      exp_q.push_back(40'hAB_CDEF_0123);
      @(posedge clk) #1 in_valid = 1'b0;
      check("t4_level", level, 16);
      check("t4_full", full, 1);
      check("t4_drop_count", drop_count, 0);
      check("t4_overflow", overflow, 0);
      drain("t4_drain");
      check("t4_empty", empty, 1);

      // 5: UART never raises busy; timeout returns to IDLE and next word launches
      busy_len = 0;
      launch_cyc_q.delete();
      push(40'h55_0000_0001, 1, pc);
      push(40'h55_0000_0002, 1, l0);
      drain("t5_drain");
      check("t5_launch_count", launch_cyc_q.size(), 2);
      check("t5_latency", (launch_cyc_q.size() == 2) ? launch_cyc_q[0] - pc : -1, 2);
      check("t5_gap", (launch_cyc_q.size() == 2) ? launch_cyc_q[1] - launch_cyc_q[0] : -1, 6);

      // 6: reset during WAIT_DONE with 7 words queued
      busy_len = 1000;
      for (int i = 0; i < 8; i++) push(W'(32'h300 + i), 1, pc);
      repeat (5) @(posedge clk);
      #1;
      check("t6_level_pre", level, 7);
      check("t6_busy_pre", out_busy, 1);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("t6_rst_level", level, 0);
      check("t6_rst_empty", empty, 1);
      check("t6_rst_out_start", out_start, 0);
      exp_q.delete();
      l0 = launches;
      @(negedge clk) rst = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      check("t6_no_launch", launches - l0, 0);
      check("t6_level_post", level, 0);
      busy_len = 2;
      push(40'h77, 1, pc);
      drain("t6_drain");
      check("t6_new_launch", launches - l0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
